// File: rtl/pipe_execute_param_if.sv
// Execute-stage bundle: E register inputs and downstream status in, e_* results out.
// master drives the E slot, slave is the execute block.
interface pipe_execute_param_if #(parameter int W = 64);
  logic         E_valid;
  logic [3:0]   E_icode, E_ifun;
  logic [2:0]   E_stat;
  logic [W-1:0] E_valC, E_valA, E_valB;
  logic [3:0]   E_dstE, E_dstM;
  logic [2:0]   m_stat, W_stat;
  logic [W-1:0] e_valE, e_valA;
  logic [3:0]   e_dstE;
  logic         e_cnd, e_stall;
  logic [2:0]   cc_out;

  modport master (
    output E_valid, E_icode, E_ifun, E_stat, E_valC, E_valA, E_valB, E_dstE, E_dstM,
           m_stat, W_stat,
    input  e_valE, e_valA, e_dstE, e_cnd, e_stall, cc_out
  );

  modport slave (
    input  E_valid, E_icode, E_ifun, E_stat, E_valC, E_valA, E_valB, E_dstE, E_dstM,
           m_stat, W_stat,
    output e_valE, e_valA, e_dstE, e_cnd, e_stall, cc_out
  );
endinterface

// File: rtl/pipe_execute_param.sv
// Y86-style execute stage: combinational ALU, registered condition codes and an
// iterative shift-add mulq that stalls the pipeline for W+1 cycles.
module pipe_execute_param #(
  parameter int W          = 64,
  parameter int STACK_STEP = 8,
  parameter int MUL_EN     = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  pipe_execute_param_if.slave ex
);
  localparam int            CW     = $clog2(W) + 1;
  localparam logic [CW-1:0] LAST   = CW'(W - 1);
  localparam logic [W-1:0]  STK    = W'(STACK_STEP);
  localparam bit            MUL_ON = (MUL_EN != 0);
  localparam logic [2:0]    AOK    = 3'b001;

  localparam logic [3:0] I_CMOV = 4'h2, I_IRMOV = 4'h3, I_RMMOV = 4'h4, I_MRMOV = 4'h5,
                         I_OPQ  = 4'h6, I_JXX   = 4'h7, I_CALL  = 4'h8, I_RET   = 4'h9,
                         I_PUSH = 4'hA, I_POP   = 4'hB;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  acc_q, acc_d, mcand_q, mcand_d, mplier_q, mplier_d;
  logic [2:0]    cc_q, cc_d;

  logic         is_mul, ok_stat, cond, cnd, of_r, stall;
  logic [W-1:0] alu_r;

  assign is_mul  = MUL_ON && (ex.E_icode == I_OPQ) && (ex.E_ifun == 4'h4);
  assign ok_stat = (ex.m_stat == AOK) && (ex.W_stat == AOK);

  // ALU; mulq only presents its product in the DONE cycle
  always_comb begin
    alu_r = '0;
    of_r  = 1'b0;
    case (ex.E_icode)
      I_CMOV:           alu_r = ex.E_valA;
      I_IRMOV:          alu_r = ex.E_valC;
      I_RMMOV, I_MRMOV: alu_r = ex.E_valB + ex.E_valC;
      I_OPQ: begin
        case (ex.E_ifun)
          4'h0: begin
            alu_r = ex.E_valB + ex.E_valA;
            of_r  = (ex.E_valA[W-1] == ex.E_valB[W-1]) && (alu_r[W-1] != ex.E_valA[W-1]);
          end
          4'h1: begin
            alu_r = ex.E_valB - ex.E_valA;
            of_r  = (ex.E_valA[W-1] != ex.E_valB[W-1]) && (alu_r[W-1] != ex.E_valB[W-1]);
          end
          4'h2: alu_r = ex.E_valB & ex.E_valA;
          4'h3: alu_r = ex.E_valB ^ ex.E_valA;
          4'h4: begin
            if (MUL_ON) begin
              alu_r = (state_q == S_DONE) ? acc_q : '0;
            end else begin
              alu_r = ex.E_valB + ex.E_valA;
              of_r  = (ex.E_valA[W-1] == ex.E_valB[W-1]) && (alu_r[W-1] != ex.E_valA[W-1]);
            end
          end
          default: alu_r = '0;
        endcase
      end
      I_CALL, I_PUSH: alu_r = ex.E_valB - STK;
      I_RET, I_POP:   alu_r = ex.E_valB + STK;
      default:        alu_r = '0;
    endcase
  end

  // cc_q = {ZF,SF,OF}
  always_comb begin
    cond = 1'b0;
    case (ex.E_ifun)
      4'h0: cond = 1'b1;
      4'h1: cond = (cc_q[1] ^ cc_q[0]) | cc_q[2];
      4'h2: cond = cc_q[1] ^ cc_q[0];
      4'h3: cond = cc_q[2];
      4'h4: cond = ~cc_q[2];
      4'h5: cond = ~(cc_q[1] ^ cc_q[0]);
      4'h6: cond = ~(cc_q[1] ^ cc_q[0]) & ~cc_q[2];
      default: cond = 1'b0;
    endcase
  end

  assign cnd = ex.E_valid && ((ex.E_icode == I_CMOV) || (ex.E_icode == I_JXX)) && cond;

  // Multiplier FSM; operands latched on start so the shift registers own them
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    stall    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ex.E_valid && is_mul) begin
          stall    = 1'b1;
          state_d  = S_MUL;
          cnt_d    = '0;
          acc_d    = '0;
          mcand_d  = ex.E_valA;
          mplier_d = ex.E_valB;
        end
      end
      S_MUL: begin
        if (!ex.E_valid || !ok_stat) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          acc_d   = '0;
        end else begin
          stall    = 1'b1;
          if (mplier_q[0]) acc_d = acc_q + mcand_q;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CW'(1);
          if (cnt_q == LAST) state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cc_d = cc_q;
    if (ex.E_valid && (ex.E_icode == I_OPQ) && ok_stat && (!is_mul || state_q == S_DONE))
      cc_d = {alu_r == '0, alu_r[W-1], of_r};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cc_q     <= 3'b100;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cc_q     <= cc_d;
    end
  end

  // reset gates stall so a held mulq in E cannot assert it while rst_n is low
  assign ex.e_stall = stall & rst_n;
  assign ex.e_valE  = alu_r;
  assign ex.e_valA  = ex.E_valA;
  assign ex.e_cnd   = cnd;
  assign ex.e_dstE  = (!ex.E_valid || ((ex.E_icode == I_CMOV) && !cnd)) ? 4'hF : ex.E_dstE;
  assign ex.cc_out  = cc_q;
endmodule

// File: doc/pipe_execute_param.md
PIPE_EXECUTE_PARAM -- requirements
Module: pipe_execute_param

Interface
REQ-001 The block SHALL provide parameter W, default 64, meaning datapath width in bits (legal: 16, 32, 64).
REQ-002 The block SHALL provide parameter STACK_STEP, default 8, meaning the stack pointer adjustment for call/ret/pushq/popq.
REQ-003 The block SHALL provide parameter MUL_EN, default 1, meaning mulq (OPq ifun 4) is supported; when 0, ifun 4 behaves as addq.
REQ-004 The block SHALL provide the following ports:
  clk  in  1  clock, rising edge active
  rst_n  in  1  reset, asynchronous, active-low
  E_valid  in  1  execute-register slot holds a live instruction (0 = bubble)
  E_icode, E_ifun  in  4 each  instruction code/function
  E_stat  in  3  instruction status
  E_valC, E_valA, E_valB  in  W each  operands
  E_dstE, E_dstM  in  4 each  destination register IDs (4'hF = none)
  m_stat, W_stat  in  3 each  downstream stage status (3'b001 = AOK)
  e_valE  out  W  ALU result
  e_valA  out  W  pass-through of E_valA
  e_dstE  out  4  effective destination
  e_cnd  out  1  condition result for cmovXX/jXX
  e_stall  out  1  execute busy; pipeline SHALL hold E inputs constant while high
  cc_out  out  3  registered {ZF,SF,OF}

Function
REQ-005 All arithmetic SHALL be W-bit two's complement, modulo 2^W.
REQ-006 Single-cycle ops SHALL produce e_valE combinationally: irmovq valC; rmmovq/mrmovq valB+valC; cmovXX valA; addq valB+valA; subq valB-valA; andq valB&valA; xorq valB^valA; call/pushq valB-STACK_STEP; ret/popq valB+STACK_STEP; all others 0.
REQ-007 e_valA SHALL equal E_valA; e_dstE SHALL equal E_dstE except 4'hF for cmovXX with e_cnd=0.
REQ-008 e_cnd SHALL evaluate registered CC for ifun 0..6 (always, le, l, e, ne, ge, g) per Y86 rules, only when icode is 2 or 7; otherwise 0; ifun >6 gives 0.
REQ-009 CC SHALL update on rising clk only when E_valid=1, E_icode=6, m_stat=3'b001 and W_stat=3'b001, and (for mulq) only on the DONE cycle.
REQ-010 Flags: ZF = result==0; SF = result[W-1]; OF add = sign(A)==sign(B) and sign(R)!=sign(A); OF sub = sign(A)!=sign(B) and sign(R)!=sign(B); OF = 0 for and/xor/mulq.
REQ-011 mulq SHALL use an FSM IDLE -> MUL -> DONE -> IDLE with iterative shift-add on a log2(W)+1-bit counter, one multiplier bit per cycle.
REQ-012 IDLE->MUL on clk when E_valid=1, E_icode=6, E_ifun=4, MUL_EN=1; e_stall SHALL be 1 combinationally in that IDLE cycle and all MUL cycles.
REQ-013 MUL SHALL last exactly W cycles, then DONE for one cycle with e_stall=0 and e_valE = low W bits of valA*valB; total latency W+1 stall cycles.
REQ-014 Abort: if E_valid=0, m_stat!=AOK or W_stat!=AOK during MUL, FSM SHALL return to IDLE next edge, e_stall SHALL drop in that cycle, CC unchanged.
REQ-015 When E_valid=0, e_cnd=0, e_dstE=4'hF, no CC update, no FSM start.
REQ-016 Other icodes SHALL never alter CC or FSM state.

Reset
REQ-017 While rst_n=0 (asynchronously): CC = {ZF=1,SF=0,OF=0}, FSM=IDLE, counter=0, multiplier accumulator=0, e_stall=0.
REQ-018 Reset asserted mid-mulq SHALL discard the operation; after release, e_stall=0 and no CC update occurs from it.

Verification
REQ-019 subq valA=3, valB=3, statuses AOK -> e_valE=0, next cycle cc_out=3'b100; then jne -> e_cnd=0, je -> e_cnd=1.
REQ-020 addq valA=valB=64'h7FFF_FFFF_FFFF_FFFF -> e_valE=64'hFFFF_FFFF_FFFF_FFFE, cc_out=3'b011; cmovl ifun 2 -> e_cnd=0, e_dstE=4'hF.
REQ-021 addq with m_stat=3'b010 -> e_valE correct, cc_out unchanged from prior value.
REQ-022 mulq valA=7, valB=-3 -> e_stall high 65 cycles, DONE e_valE=-21 (64'hFFFF_FFFF_FFFF_FFEB), cc_out=3'b010.
REQ-023 mulq started, W_stat=3'b011 at MUL cycle 10 -> e_stall low next cycle, FSM IDLE, CC unchanged.
REQ-024 pushq valB=0x100 -> e_valE=0xF8; popq valB=0x100 -> 0x108; rst_n low mid-mulq -> e_stall=0 immediately, cc_out=3'b100.
